// File: rtl/fadd_issue_ctrl.sv
// Operand pairing, issue and result collection in front of a fixed-latency FP adder.
// Output FIFO credits cover every in-flight sum, so a capture never overflows.

module fadd_issue_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;

  // Storage has no reset; emptiness is carried by r_cnt alone.
  always_ff @(posedge clock)
    if (i_push) r_mem[r_wp] <= i_wdata;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + AW'(1);
      if (i_pop)  r_rp <= r_rp + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign o_head = r_mem[r_rp];
  assign o_cnt  = r_cnt;
endmodule

module fadd_issue_ctrl #(
  parameter int DATA_W      = 32,
  parameter int IN_DEPTH    = 4,
  parameter int ADD_LATENCY = 12,
  parameter int OUT_DEPTH   = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  output logic [DATA_W-1:0] dataa,
  output logic [DATA_W-1:0] datab,
  output logic              validdataa,
  output logic              validdatab,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int AW = $clog2(IN_DEPTH);
  localparam int OW = $clog2(OUT_DEPTH);
  localparam int FW = $clog2(ADD_LATENCY + 1);
  localparam logic [AW:0] IN_FULL = (AW+1)'(IN_DEPTH);

  logic                   r_rdy_en;
  logic [ADD_LATENCY-1:0] r_vld;
  logic [FW-1:0]          r_in_flight;

  logic [DATA_W-1:0] w_a_head, w_b_head, w_o_head;
  logic [AW:0]       w_a_cnt, w_b_cnt;
  logic [OW:0]       w_o_cnt;
  logic              w_a_push, w_b_push, w_issue, w_cap, w_pop, w_credit;
  logic [31:0]       w_occ;

  assign a_ready  = r_rdy_en && (w_a_cnt != IN_FULL);
  assign b_ready  = r_rdy_en && (w_b_cnt != IN_FULL);
  assign w_a_push = a_valid && a_ready;
  assign w_b_push = b_valid && b_ready;

  // Credit counts sums in the adder plus sums already parked in the output FIFO.
  assign w_occ    = 32'(r_in_flight) + 32'(w_o_cnt);
  assign w_credit = w_occ < 32'(OUT_DEPTH);
  assign w_issue  = (w_a_cnt != '0) && (w_b_cnt != '0) && w_credit;
  assign w_cap    = r_vld[ADD_LATENCY-1];
  assign w_pop    = out_valid && out_ready;

  fadd_issue_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_fifo_a (
    .clock(clock), .resetn(resetn), .i_push(w_a_push), .i_wdata(a_data),
    .i_pop(w_issue), .o_head(w_a_head), .o_cnt(w_a_cnt)
  );

  fadd_issue_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_fifo_b (
    .clock(clock), .resetn(resetn), .i_push(w_b_push), .i_wdata(b_data),
    .i_pop(w_issue), .o_head(w_b_head), .o_cnt(w_b_cnt)
  );

  fadd_issue_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_fifo_o (
    .clock(clock), .resetn(resetn), .i_push(w_cap), .i_wdata(result),
    .i_pop(w_pop), .o_head(w_o_head), .o_cnt(w_o_cnt)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rdy_en    <= 1'b0;
      r_vld       <= '0;
      r_in_flight <= '0;
      dataa       <= '0;
      datab       <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_vld    <= {r_vld[ADD_LATENCY-2:0], w_issue};
      if (w_issue) begin
        dataa <= w_a_head;
        datab <= w_b_head;
      end
      case ({w_issue, w_cap})
        2'b10:   r_in_flight <= r_in_flight + FW'(1);
        2'b01:   r_in_flight <= r_in_flight - FW'(1);
        default: ;
      endcase
    end
  end

  assign validdataa = r_vld[0];
  assign validdatab = r_vld[0];
  assign out_valid  = (w_o_cnt != '0);
  assign out_data   = out_valid ? w_o_head : '0;

  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(w_cap && (w_o_cnt == (OW+1)'(OUT_DEPTH))));
endmodule

// File: doc/fadd_issue_ctrl.md
Name: fadd_issue_ctrl

Overview:
- Credit-based operand issue and result-collection stage that sits directly in front of the pipelined single-precision adder wrapper.
- Buffers two independent operand streams in small FIFOs and pairs them in order, one A with one B.
- Issues each pair to the adder with a one-cycle valid pulse and tracks in-flight operations with a valid shift register matched to the adder's fixed latency.
- Captures each sum into an output FIFO with ready/valid backpressure. Credit accounting guarantees no result is ever dropped.

Parameters:
- DATA_W, 32: operand/result width (IEEE-754 single).
- IN_DEPTH, 4: depth of each operand FIFO (power of 2).
- ADD_LATENCY, 12: edges from the edge that raises validdataa/validdatab to the edge at which the matching sum is stable on result. Includes the wrapper's output register.
- OUT_DEPTH, 16: output FIFO depth (power of 2, >= 2).

Ports:
- clock, in, 1: single clock, rising edge.
- resetn, in, 1: asynchronous active-low reset.
- a_data, in, DATA_W: operand A stream data.
- a_valid, in, 1: operand A valid.
- a_ready, out, 1: operand A FIFO not full.
- b_data, in, DATA_W: operand B stream data.
- b_valid, in, 1: operand B valid.
- b_ready, out, 1: operand B FIFO not full.
- dataa, out, DATA_W: to adder, registered operand A.
- datab, out, DATA_W: to adder, registered operand B.
- validdataa, out, 1: to adder, issue pulse.
- validdatab, out, 1: to adder, identical to validdataa.
- result, in, DATA_W: sum from the adder wrapper.
- out_data, out, DATA_W: head of output FIFO.
- out_valid, out, 1: output FIFO not empty.
- out_ready, in, 1: downstream accepts out_data.

Behaviour:
- Reset (async assert, sync release): all of the following clear.
  - FIFOs are emptied.
  - Valid shift register and in_flight counter clear to 0.
  - a_ready = b_ready = 0 while resetn = 0, then 1 from the first edge after release.
  - dataa = datab = 0, validdataa = validdatab = 0.
  - out_valid = 0, out_data = 0.
- Reset mid-operation: sums still in the adder pipeline are discarded, because the shift register is cleared and nothing is captured.
- Input FIFOs:
  - Push on a_valid & a_ready (B likewise). a_ready = !full_A.
  - A full FIFO ignores a_valid. No overflow is ever possible.
  - Each FIFO has independent wrap-around pointers plus a count of 0..IN_DEPTH.
- Issue condition, evaluated each cycle: !empty_A & !empty_B & (in_flight + out_count < OUT_DEPTH).
  - When true: pop both FIFO heads, load them into dataa/datab, and set validdataa = validdatab = 1 for exactly one cycle.
  - When false: validdataa = validdatab = 0; dataa/datab hold their last value.
  - At most one issue per cycle. Back-to-back issue every cycle is allowed.
- Pairing: strictly in order. The k-th accepted A is added to the k-th accepted B. An unmatched operand waits indefinitely.
- Tracking:
  - Shift register vld[ADD_LATENCY-1:0]; vld[0] is loaded with the issue bit.
  - The tap at vld[ADD_LATENCY-1] marks the cycle when result holds the matching sum. On that edge, result is written to the output FIFO.
  - in_flight is incremented on issue and decremented on capture; when both occur together it is unchanged. Range 0..ADD_LATENCY.
- Latency: for an input handshake at edge e with the partner operand already present:
  - validdataa is high from edge e+1 to edge e+2.
  - Capture happens at edge e+1+ADD_LATENCY.
  - out_valid rises after edge e+1+ADD_LATENCY (13 edges at default).
- Output FIFO:
  - out_data = head entry, out_valid = !empty. Pop on out_valid & out_ready.
  - Simultaneous capture and pop leave out_count unchanged.
- Credit guarantee: capture never finds the output FIFO full. A capture into a full FIFO is a design error, flagged by assertion.
- Throughput: with out_ready held at 1, one result per cycle is sustained indefinitely. The reason is that a pop frees a credit before the next capture, because credit uses the registered out_count.
- No arithmetic is performed in this block. Data passes bit-exact, and special values (NaN, Inf, denormal) are untouched.

Test Plan:
- Single pair: a_data = 0x3F800000 (1.0), b_data = 0x40000000 (2.0) handshaken at the same edge, out_ready = 1.
  - Required: exactly one validdataa pulse 1 edge later.
  - Required: out_data = 0x40400000 (3.0) with out_valid high 13 edges after the handshake, then out_valid drops.
- Skewed streams: 3 A values pushed, B values pushed 5 cycles later.
  - Required: no issue until the first B arrives.
  - Required: sums emerge in order, matching A[k] + B[k].
- Streaming: 100 random pairs pushed every cycle, out_ready = 1.
  - Required: validdataa high 100 consecutive cycles once primed.
  - Required: 100 results, in order, with no gaps.
- Backpressure: out_ready = 0, 40 pairs offered.
  - Required: issues stop once in_flight + out_count = 16.
  - Required: a_ready/b_ready drop after 4 more are buffered per FIFO.
  - Required: after out_ready = 1, all 40 sums arrive in order with none lost.
- Reset mid-flight: 5 pairs issued, resetn pulsed low 3 edges later.
  - Required: outputs at reset values immediately.
  - Required: no out_valid for the discarded sums.
  - Required: a fresh 1.0 + 1.0 afterwards returns 0x40000000.
- FIFO full: 6 A values offered, no B.
  - Required: a_ready = 0 after 4 accepted, with the 5th and 6th held off.
  - Required: supplying 4 B values yields exactly 4 results.
